// File: rtl/ofs_fim_pcie_ss_rx_hdr_to_sb_pkg.sv
// Shared types and defaults for the RX header-to-sideband shim.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ofs_fim_pcie_ss_rx_hdr_to_sb_pkg;

    // Default in-band PCIe SS header size in bytes
    localparam int HDR_BYTES_DEFAULT = 32;

    // Packet-level state of the header-to-sideband converter
    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // waiting for an SOP beat
        BODY  = 2'd1,   // packet in progress, carry holds live bytes
        FLUSH = 2'd2    // tlast taken, carry still holds the final bytes
    } t_hdr_sb_state;

endpackage

// File: rtl/ofs_fim_pcie_ss_rx_hdr_to_sb_if.sv
// Stream bundle around the header-to-sideband shim: aligned input, sideband-header output.
// Latency: n/a (wires only).
// Backpressure: tready per direction; slave modport is the shim, master is its environment.
interface ofs_fim_pcie_ss_rx_hdr_to_sb_if
    import ofs_fim_pcie_ss_rx_hdr_to_sb_pkg::*;
#(
    parameter int TDATA_WIDTH = 512,
    parameter int HDR_WIDTH   = HDR_BYTES_DEFAULT * 8
);
    // Aligned input stream, header in-band at slot 0 on SOP
    logic                       in_tvalid;
    logic                       in_tready;
    logic [TDATA_WIDTH-1:0]     in_tdata;
    logic [TDATA_WIDTH/8-1:0]   in_tkeep;
    logic                       in_tlast;
    logic                       in_sop;

    // Payload-only output stream with the header moved to sideband
    logic                       out_tvalid;
    logic                       out_tready;
    logic [TDATA_WIDTH-1:0]     out_tdata;
    logic [TDATA_WIDTH/8-1:0]   out_tkeep;
    logic                       out_tlast;
    logic                       out_hvalid;
    logic [HDR_WIDTH-1:0]       out_hdr;

    modport slave (
        input  in_tvalid, in_tdata, in_tkeep, in_tlast, in_sop,
        output in_tready,
        output out_tvalid, out_tdata, out_tkeep, out_tlast, out_hvalid, out_hdr,
        input  out_tready
    );

    modport master (
        output in_tvalid, in_tdata, in_tkeep, in_tlast, in_sop,
        input  in_tready,
        input  out_tvalid, out_tdata, out_tkeep, out_tlast, out_hvalid, out_hdr,
        output out_tready
    );

endinterface

// File: rtl/ofs_fim_pcie_ss_rx_hdr_to_sb_pipe.sv
// One-entry output register for a valid/ready stream of W-bit beats.
// Latency: 1 cycle from in_vld&in_rdy to out_vld.
// Backpressure: in_rdy when empty or being drained; data held while out_vld&!out_rdy.
module ofs_fim_pcie_ss_rx_hdr_to_sb_pipe #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         in_rdy,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    // Accept a new beat whenever the slot is empty or drains this cycle
    assign in_rdy = !out_vld || out_rdy;

    // Register the beat; stall holds contents untouched
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (in_rdy) begin
            out_vld <= in_vld;
            if (in_vld) begin
                out_dat <= in_dat;
            end
        end
    end

endmodule

// File: rtl/ofs_fim_pcie_ss_rx_hdr_to_sb.sv
// Strips the slot-0 in-band header to sideband and shifts payload down by HDR_BYTES.
// Latency: 1 cycle after the 2nd input beat (multi-beat) or after the only beat (single-beat).
// Backpressure: in_tready follows the output register; dropped for one cycle while flushing.
module ofs_fim_pcie_ss_rx_hdr_to_sb
    import ofs_fim_pcie_ss_rx_hdr_to_sb_pkg::*;
#(
    parameter int TDATA_WIDTH = 512,
    parameter int HDR_WIDTH   = HDR_BYTES_DEFAULT * 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ofs_fim_pcie_ss_rx_hdr_to_sb_if.slave bus
);

    localparam int DW = TDATA_WIDTH;
    localparam int HW = HDR_WIDTH;
    localparam int KW = DW / 8;
    localparam int HK = HW / 8;
    localparam int CW = DW - HW;   // carried (upper) data width
    localparam int CK = CW / 8;

    typedef struct packed {
        logic          hvalid;
        logic [HW-1:0] hdr;
        logic          tlast;
        logic [KW-1:0] tkeep;
        logic [DW-1:0] tdata;
    } beat_t;

    t_hdr_sb_state state;
    logic [CW-1:0] carry_dat;
    logic [CK-1:0] carry_keep;
    logic [HW-1:0] hdr_q;
    logic          hdr_pend;     // header not yet attached to an output beat

    logic          ld_rdy;
    logic          acc;
    logic          nxt_vld;
    beat_t         nxt;
    logic          q_vld;
    beat_t         q;

    logic [HW-1:0] lo_dat;
    logic [HK-1:0] lo_keep;
    logic [CW-1:0] up_dat;
    logic [CK-1:0] up_keep;

    assign lo_dat  = bus.in_tdata[HW-1:0];
    assign lo_keep = bus.in_tkeep[HK-1:0];
    assign up_dat  = bus.in_tdata[DW-1:HW];
    assign up_keep = bus.in_tkeep[KW-1:HK];

    assign bus.in_tready = rst_n && (state != FLUSH) && ld_rdy;
    assign acc           = bus.in_tvalid && bus.in_tready;

    // Build the candidate output beat from the input beat and the carry
    always_comb begin
        nxt     = '0;
        nxt_vld = 1'b0;
        case (state)
            IDLE: begin
                // Single-beat packet: the upper half goes straight out
                if (acc && bus.in_sop && bus.in_tlast) begin
                    nxt_vld    = 1'b1;
                    nxt.hvalid = 1'b1;
                    nxt.hdr    = lo_dat;
                    nxt.tlast  = 1'b1;
                    nxt.tkeep  = {{HK{1'b0}}, up_keep};
                    nxt.tdata  = {{HW{1'b0}}, up_dat};
                end
            end
            BODY: begin
                if (acc) begin
                    nxt_vld    = 1'b1;
                    nxt.hvalid = hdr_pend;
                    nxt.hdr    = hdr_q;
                    nxt.tlast  = bus.in_tlast && (up_keep == '0);
                    nxt.tkeep  = {lo_keep, carry_keep};
                    nxt.tdata  = {lo_dat, carry_dat};
                end
            end
            FLUSH: begin
                nxt_vld    = 1'b1;
                nxt.hdr    = hdr_q;
                nxt.tlast  = 1'b1;
                nxt.tkeep  = {{HK{1'b0}}, carry_keep};
                nxt.tdata  = {{HW{1'b0}}, carry_dat};
            end
            default: ;
        endcase
    end

    // Packet FSM with carry and header registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            carry_dat  <= '0;
            carry_keep <= '0;
            hdr_q      <= '0;
            hdr_pend   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A non-SOP beat here is dropped
                    if (acc && bus.in_sop) begin
                        hdr_q      <= lo_dat;
                        carry_dat  <= up_dat;
                        carry_keep <= up_keep;
                        if (!bus.in_tlast) begin
                            hdr_pend <= 1'b1;
                            state    <= BODY;
                        end
                    end
                end
                BODY: begin
                    if (acc) begin
                        carry_dat  <= up_dat;
                        carry_keep <= up_keep;
                        hdr_pend   <= 1'b0;
                        if (bus.in_tlast) begin
                            state <= (up_keep == '0) ? IDLE : FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (ld_rdy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Beats outside a packet mean the upstream aligner lost SOP framing
    a_sop_in_idle: assert property (@(posedge clk) disable iff (!rst_n)
        (state == IDLE && acc) |-> bus.in_sop)
        else $error("rx_hdr_to_sb: non-SOP beat accepted while idle, dropped");

    ofs_fim_pcie_ss_rx_hdr_to_sb_pipe #(
        .W ($bits(beat_t))
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (nxt_vld),
        .in_dat  (nxt),
        .in_rdy  (ld_rdy),
        .out_vld (q_vld),
        .out_rdy (bus.out_tready),
        .out_dat (q)
    );

    assign bus.out_tvalid = q_vld;
    assign bus.out_tdata  = q.tdata;
    assign bus.out_tkeep  = q.tkeep;
    assign bus.out_tlast  = q.tlast;
    assign bus.out_hvalid = q.hvalid;
    assign bus.out_hdr    = q.hdr;

endmodule

// File: tb/tb_ofs_fim_pcie_ss_rx_hdr_to_sb.sv
// Bench for the header-to-sideband shim: directed packets, random traffic, mid-packet reset.
// Latency: n/a.
// Backpressure: randomised out_tready and input gaps.
module tb_ofs_fim_pcie_ss_rx_hdr_to_sb;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int HW = 256;
    localparam int HB = 32;
    localparam int BB = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ofs_fim_pcie_ss_rx_hdr_to_sb_if #(.TDATA_WIDTH(DW), .HDR_WIDTH(HW)) bus ();

    ofs_fim_pcie_ss_rx_hdr_to_sb #(.TDATA_WIDTH(DW), .HDR_WIDTH(HW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [DW-1:0] dat;
        logic [KW-1:0] keep;
        logic          last;
        logic          sop;
    } ibeat_t;

    typedef struct {
        logic [DW-1:0] dat;
        logic [KW-1:0] keep;
        logic          last;
        logic          hv;
        logic [HW-1:0] hdr;
    } obeat_t;

    ibeat_t inq[$];
    obeat_t expq[$];
    int total = 0;
    int bad = 0;
    int exp_flush = 0;
    int stalls = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] kmask(input logic [KW-1:0] k);
        logic [DW-1:0] m;
        m = '0;
        for (int i = 0; i < KW; i++) if (k[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [HW-1:0] rhdr();
        logic [HW-1:0] h;
        for (int i = 0; i < HW/32; i++) h[32*i +: 32] = $urandom();
        return h;
    endfunction

    // Model: header + n payload bytes as a byte stream; output is the payload cut into 64-byte beats
    task automatic add_pkt(input logic [HW-1:0] hdr, input int n);
        byte unsigned pay[];
        int tot, nin, nout, idx;
        ibeat_t ib;
        obeat_t ob;
        pay = new[n];
        for (int i = 0; i < n; i++) pay[i] = 8'($urandom());
        tot = HB + n;
        nin = (tot + BB - 1) / BB;
        for (int b = 0; b < nin; b++) begin
            ib.dat = '0; ib.keep = '0;
            for (int j = 0; j < BB; j++) begin
                idx = b*BB + j;
                if (idx < HB) begin
                    ib.dat[8*j +: 8] = hdr[8*idx +: 8]; ib.keep[j] = 1'b1;
                end else if (idx < tot) begin
                    ib.dat[8*j +: 8] = pay[idx-HB]; ib.keep[j] = 1'b1;
                end else begin
                    ib.dat[8*j +: 8] = 8'($urandom());
                end
            end
            ib.sop  = (b == 0);
            ib.last = (b == nin-1);
            inq.push_back(ib);
        end
        // Multi-beat packet whose last beat reaches past the header slot needs an extra carry beat
        if (nin > 1 && (tot - BB*(nin-1)) > HB) exp_flush++;
        nout = (n == 0) ? 1 : (n + BB - 1) / BB;
        for (int k = 0; k < nout; k++) begin
            ob.dat = '0; ob.keep = '0;
            for (int j = 0; j < BB; j++) begin
                idx = k*BB + j;
                if (idx < n) begin
                    ob.dat[8*j +: 8] = pay[idx]; ob.keep[j] = 1'b1;
                end
            end
            ob.hv   = (k == 0);
            ob.last = (k == nout-1);
            ob.hdr  = hdr;
            expq.push_back(ob);
        end
    endtask

    task automatic drive_in(input ibeat_t b);
        bus.in_tvalid = 1'b1;
        bus.in_tdata  = b.dat;
        bus.in_tkeep  = b.keep;
        bus.in_tlast  = b.last;
        bus.in_sop    = b.sop;
    endtask

    task automatic run(input int rdy_pct, input int vld_pct, input int budget);
        int cyc;
        logic hold;
        logic [DW-1:0] hold_dat;
        obeat_t e;
        cyc = 0; hold = 1'b0; hold_dat = '0;
        while ((inq.size() > 0 || expq.size() > 0) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            bus.out_tready = ($urandom_range(99) < rdy_pct);
            if (inq.size() > 0 && $urandom_range(99) < vld_pct) drive_in(inq[0]);
            else bus.in_tvalid = 1'b0;
            #1;
            if (hold) begin
                chk("hold_vld", bus.out_tvalid, 1);
                chk("hold_dat", bus.out_tdata, hold_dat);
            end
            hold     = bus.out_tvalid && !bus.out_tready;
            hold_dat = bus.out_tdata;
            if (bus.out_tvalid && bus.out_tready) begin
                if (expq.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("keep", bus.out_tkeep, e.keep);
                    chk("last", bus.out_tlast, e.last);
                    chk("hvalid", bus.out_hvalid, e.hv);
                    if (e.hv) chk("hdr", bus.out_hdr, e.hdr);
                    chk("data", bus.out_tdata & kmask(e.keep), e.dat);
                end
            end
            if (bus.in_tvalid) begin
                if (bus.in_tready) void'(inq.pop_front());
                else stalls++;
            end
        end
        if (inq.size() > 0 || expq.size() > 0) chk("timeout", inq.size() + expq.size(), 0);
    endtask

    initial begin
        int guard;
        bus.in_tvalid  = 1'b0;
        bus.in_tdata   = '0;
        bus.in_tkeep   = '0;
        bus.in_tlast   = 1'b0;
        bus.in_sop     = 1'b0;
        bus.out_tready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tvalid", bus.out_tvalid, 0);
        chk("rst_tkeep", bus.out_tkeep, 0);
        chk("rst_tlast", bus.out_tlast, 0);
        chk("rst_hvalid", bus.out_hvalid, 0);
        chk("rst_tready", bus.in_tready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed shapes: 16-byte single beat, header-only, 96 bytes (flush), 64 bytes (no flush)
        add_pkt({32{8'hA5}}, 16);
        run(100, 100, 200);
        add_pkt(rhdr(), 0);
        run(100, 100, 200);
        add_pkt(rhdr(), 96);
        run(100, 100, 200);
        add_pkt(rhdr(), 64);
        run(100, 100, 200);

        // Random back-to-back traffic under random backpressure
        for (int p = 0; p < 24; p++) add_pkt(rhdr(), $urandom_range(0, 200));
        run(50, 80, 4000);

        // Ready held high, input always valid: only flush cycles may stall the input
        exp_flush = 0;
        stalls = 0;
        for (int p = 0; p < 12; p++) add_pkt(rhdr(), $urandom_range(1, 250));
        add_pkt(rhdr(), 0);
        run(100, 100, 2000);
        chk("no_bubble_stalls", stalls, exp_flush);

        // Reset mid-packet with an output beat pending
        add_pkt(rhdr(), 150);
        for (int b = 0; b < 2; b++) begin
            guard = 0;
            do begin
                @(negedge clk);
                bus.out_tready = 1'b0;
                drive_in(inq[0]);
                #1;
                guard++;
            end while (!bus.in_tready && guard < 20);
            if (!bus.in_tready) chk("rst_seq_accept", 0, 1);
            else void'(inq.pop_front());
        end
        @(negedge clk);
        bus.in_tvalid = 1'b0;
        #1;
        chk("pre_rst_tvalid", bus.out_tvalid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tready", bus.in_tready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_tvalid", bus.out_tvalid, 0);
        chk("post_rst_hvalid", bus.out_hvalid, 0);
        inq.delete();
        expq.delete();
        add_pkt(rhdr(), 100);
        add_pkt(rhdr(), 20);
        run(70, 90, 400);

        @(negedge clk);
        bus.in_tvalid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
